// File: rtl/fpu_writeback.sv
// Float register file writeback: merges never-stalling pipe results with buffered multi-cycle results,
// tracks busy destinations for decode stalls and accumulates sticky IEEE flags.
module fpu_writeback #(
  parameter int XLEN          = 32,
  parameter int LOG2_FRF_SIZE = 5,
  parameter int MC_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_valid,
  input  logic [LOG2_FRF_SIZE-1:0] pipe_rd,
  input  logic [XLEN-1:0]          pipe_data,
  input  logic [4:0]               pipe_flags,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [LOG2_FRF_SIZE-1:0] mc_rd,
  input  logic [XLEN-1:0]          mc_data,
  input  logic [4:0]               mc_flags,
  input  logic                     issue_valid,
  input  logic [LOG2_FRF_SIZE-1:0] issue_rd,
  input  logic [LOG2_FRF_SIZE-1:0] dec_rs1,
  input  logic [LOG2_FRF_SIZE-1:0] dec_rs2,
  input  logic [LOG2_FRF_SIZE-1:0] dec_rd,
  output logic                     hazard,
  output logic                     FRegWrite,
  output logic [LOG2_FRF_SIZE-1:0] frf_rd,
  output logic [XLEN-1:0]          frf_data,
  input  logic                     fflags_we,
  input  logic [4:0]               fflags_wdata,
  output logic [4:0]               fflags
);

  localparam int NREGS = 1 << LOG2_FRF_SIZE;

  typedef struct packed {
    logic [LOG2_FRF_SIZE-1:0] rd;
    logic [XLEN-1:0]          data;
    logic [4:0]               flags;
  } mc_entry_t;

  mc_entry_t        fifo_mem [2];
  logic             head_ptr;
  logic             tail_ptr;
  logic [1:0]       count;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  mc_entry_t        head;
  logic             push;
  logic             pop;
  logic [4:0]       commit_flags;
  logic [4:0]       fflags_base;

  // Full is judged on registered occupancy only, so a pop never frees a slot in the same cycle.
  assign mc_ready = (count != 2'(MC_FIFO_DEPTH));
  assign push     = mc_valid & mc_ready;
  assign head     = fifo_mem[head_ptr];
  assign pop      = ~pipe_valid & (count != 2'd0);
  assign hazard   = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

  always_comb begin
    busy_nxt = busy;
    if (pop)         busy_nxt[head.rd]  = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
  end

  always_comb begin
    commit_flags = 5'd0;
    if (pipe_valid) commit_flags = pipe_flags;
    else if (pop)   commit_flags = head.flags;
    fflags_base = fflags_we ? fflags_wdata : fflags;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_ptr] <= '{rd: mc_rd, data: mc_data, flags: mc_flags};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) tail_ptr <= ~tail_ptr;
      if (pop)  head_ptr <= ~head_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FRegWrite <= 1'b0;
      frf_rd    <= '0;
      frf_data  <= '0;
      fflags    <= 5'd0;
      busy      <= '0;
    end else begin
      busy   <= busy_nxt;
      fflags <= fflags_base | commit_flags;
      if (pipe_valid) begin
        FRegWrite <= 1'b1;
        frf_rd    <= pipe_rd;
        frf_data  <= pipe_data;
      end else if (pop) begin
        FRegWrite <= 1'b1;
        frf_rd    <= head.rd;
        frf_data  <= head.data;
      end else begin
        FRegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fpu_writeback.md
Name: fpu_writeback

Overview:
- Writeback stage placed directly upstream of the float register file. It drives that file's write port (FRegWrite, rd, datain).
- Merges results from two sources:
  - the single-cycle FPU pipeline, which can never be stalled;
  - the multi-cycle divide/sqrt unit, through a valid/ready handshake and a 2-entry FIFO.
- Keeps a per-register busy scoreboard so decode can stall on pending multi-cycle destinations.
- Accumulates sticky IEEE exception flags (fflags) for fcsr.

Parameters:
- XLEN, 32, data width of float registers and results.
- LOG2_FRF_SIZE, 5, float register index width (32 registers).
- MC_FIFO_DEPTH, 2, multi-cycle result buffer depth (fixed at 2; the parameter exists for documentation only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  single-cycle FPU result valid; always accepted.
- pipe_rd  in  LOG2_FRF_SIZE  destination of pipe result.
- pipe_data  in  XLEN  pipe result.
- pipe_flags  in  5  NV,DZ,OF,UF,NX of pipe result.
- mc_valid  in  1  multi-cycle result valid.
- mc_ready  out  1  multi-cycle result accepted this cycle.
- mc_rd  in  LOG2_FRF_SIZE  destination of mc result.
- mc_data  in  XLEN  mc result.
- mc_flags  in  5  mc exception flags.
- issue_valid  in  1  a multi-cycle op is issued this cycle.
- issue_rd  in  LOG2_FRF_SIZE  its destination register.
- dec_rs1  in  LOG2_FRF_SIZE  decode source 1.
- dec_rs2  in  LOG2_FRF_SIZE  decode source 2.
- dec_rd  in  LOG2_FRF_SIZE  decode destination.
- hazard  out  1  decode must stall.
- FRegWrite  out  1  register file write enable.
- frf_rd  out  LOG2_FRF_SIZE  register file write index.
- frf_data  out  XLEN  register file write data.
- fflags_we  in  1  CSR write of fflags.
- fflags_wdata  in  5  CSR write value.
- fflags  out  5  sticky accumulated flags.

Behaviour:
- Reset (async, rst_n low): FRegWrite=0, frf_rd=0, frf_data=0, fflags=0, all busy bits 0, FIFO empty.
  - mc_ready reads 1 while rst_n is low.
  - Reset mid-operation discards all FIFO contents and pending busy bits.
- mc_ready = FIFO not full. This is combinational from state only and does not depend on mc_valid.
- The mc handshake completes on a rising edge where mc_valid & mc_ready are both 1. {mc_rd, mc_data, mc_flags} are pushed to the FIFO tail.
- Write-port arbitration, evaluated each edge; all outputs are registered:
  - pipe_valid=1: FRegWrite<=1, frf_rd<=pipe_rd, frf_data<=pipe_data. Pipe always wins.
  - else FIFO non-empty: pop head, FRegWrite<=1, frf_rd/frf_data<=head.
  - else FRegWrite<=0. frf_rd and frf_data hold their previous values.
- Latency:
  - pipe: 1 cycle, input at edge N gives the write active in the cycle after edge N.
  - mc: minimum 2 edges; push at edge N, pop at edge N+1.
  - No bypass of the FIFO.
- FIFO full with a simultaneous pop: mc_ready is still 0 that cycle (no same-cycle push-on-pop). Push and pop together are legal when not full; occupancy is unchanged.
- FIFO order is strictly FIFO.
- Scoreboard (busy[0..31]):
  - Set on an edge with issue_valid, at bit issue_rd.
  - Cleared on the edge where an mc entry is popped to the write port, at bit of the head rd.
  - If set and clear target the same register on the same edge, set wins.
  - Pipe writes never clear busy bits.
- hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]. Combinational. f0 is not special.
- WAW between pipe and mc is prevented upstream by hazard. This block does no checking.
- fflags update, per edge:
  - new = fflags_we ? fflags_wdata : fflags.
  - fflags <= new | (write-port flags of the entry selected this edge, i.e. pipe_flags or FIFO head flags; 0 if none).
  - Flags are accumulated when the result is committed, not when the mc handshake completes.

Test Plan:
- Reset then pipe_valid=1, pipe_rd=3, pipe_data=32'h3F800000, flags=5'b00001 for one cycle -> next cycle FRegWrite=1, frf_rd=3, frf_data=32'h3F800000; fflags=5'b00001; FRegWrite=0 afterwards.
- issue_valid, issue_rd=7; later mc result rd=7 data=32'h40490FDB with no pipe traffic -> hazard=1 whenever dec_rs1=7 until the write cycle; FRegWrite for rd=7 occurs 2 edges after the handshake; busy[7] clears on that edge.
- Hold pipe_valid=1 continuously and present 3 mc results (rd=1,2,3) -> mc_ready drops to 0 after 2 pushes; the third waits; after pipe_valid drops, writes occur in order rd=1,2,3 on consecutive cycles.
- Same edge: issue_valid with issue_rd=5 and FIFO head popping with rd=5 -> busy[5]=1 after the edge; hazard stays 1 for dec_rs2=5.
- fflags=5'b00100, then fflags_we=1 wdata=0 in the same cycle a pipe result with flags=5'b10000 commits -> fflags=5'b10000.
- Assert rst_n=0 asynchronously with 2 FIFO entries and busy[9]=1 -> all outputs return to 0 immediately, mc_ready=1, and no stale write appears after release.
